// File: rtl/seg_digit_monitor_if.sv
// ============================================================================
// seg_digit_monitor_if
// Segment-bus monitor interface: sampled segment input plus decoded results.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface seg_digit_monitor_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       seg_in;
  logic [3:0]       digit_out;
  logic             digit_vld;
  logic             step_err;
  logic             seg_illegal;
  logic             locked;
  logic [CNT_W-1:0] chg_cnt;

  modport master (
    output seg_in,
    input  digit_out, digit_vld, step_err, seg_illegal, locked, chg_cnt
  );

  modport slave (
    input  seg_in,
    output digit_out, digit_vld, step_err, seg_illegal, locked, chg_cnt
  );
endinterface

`default_nettype wire

// File: rtl/seg_digit_monitor.sv
// ============================================================================
// seg_digit_monitor
// Glitch-filters a 7-segment bus, decodes it to BCD and checks +1 mod 10 steps.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_digit_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int CNT_W         = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  seg_digit_monitor_if.slave bus
);

  localparam int               RUN_W   = $clog2(STABLE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {
    EMPTY  = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [7:0]       r_seg_q;
  logic [7:0]       r_last_pat;
  logic [RUN_W-1:0] r_run;
  logic             r_acc;
  logic [3:0]       r_digit;
  logic             r_vld;
  logic             r_err;
  logic             r_ill;
  logic [CNT_W-1:0] r_cnt;

  logic [7:0]       w_seg_in;
  logic             w_changed;
  logic             w_accept;
  logic             w_is_digit;
  logic [3:0]       w_digit;
  logic [3:0]       w_next_digit;

  // dp never participates, so it is dropped before the stability compare too
  assign w_seg_in     = (ACTIVE_LOW ? ~bus.seg_in : bus.seg_in) & 8'h7F;
  assign w_changed    = (w_seg_in != r_seg_q);
  assign w_accept     = (r_run == RUN_MAX) && !r_acc;
  assign w_next_digit = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;

  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'd0;
    case (r_seg_q[6:0])
      7'h3F: w_digit = 4'd0;
      7'h06: w_digit = 4'd1;
      7'h5B: w_digit = 4'd2;
      7'h4F: w_digit = 4'd3;
      7'h66: w_digit = 4'd4;
      7'h6D: w_digit = 4'd5;
      7'h7D: w_digit = 4'd6;
      7'h07: w_digit = 4'd7;
      7'h7F: w_digit = 4'd8;
      7'h6F: w_digit = 4'd9;
      default: w_is_digit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_seg_q    <= 8'h00;
      r_last_pat <= 8'h00;
      r_run      <= '0;
      r_acc      <= 1'b1;
      r_digit    <= 4'd0;
      r_vld      <= 1'b0;
      r_err      <= 1'b0;
      r_ill      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_vld <= 1'b0;
      r_err <= 1'b0;
      r_ill <= 1'b0;

      if (w_changed) begin
        r_seg_q <= w_seg_in;
        r_run   <= '0;
        r_acc   <= 1'b0;
      end else begin
        if (r_run != RUN_MAX) begin
          r_run <= r_run + 1'b1;
        end
        if (w_accept) begin
          r_acc <= 1'b1;
        end
      end

      // Re-accepting the held pattern (e.g. after a short glitch) is silent
      if (w_accept && (r_seg_q != r_last_pat)) begin
        r_last_pat <= r_seg_q;
        if (w_is_digit) begin
          r_vld   <= 1'b1;
          r_err   <= (r_state == LOCKED) && (w_digit != w_next_digit);
          r_digit <= w_digit;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= LOCKED;
        end else begin
          r_ill   <= (r_seg_q != 8'h00);
          r_state <= EMPTY;
        end
      end
    end
  end

  assign bus.digit_out   = r_digit;
  assign bus.digit_vld   = r_vld;
  assign bus.step_err    = r_err;
  assign bus.seg_illegal = r_ill;
  assign bus.locked      = (r_state == LOCKED);
  assign bus.chg_cnt     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_seg_digit_monitor.sv
// ============================================================================
// tb_seg_digit_monitor
// Randomized + directed bench for seg_digit_monitor, active-high and active-low.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg_digit_monitor;

  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_digit_monitor_if #(.CNT_W(8)) bus_a ();
  seg_digit_monitor_if #(.CNT_W(8)) bus_b ();

  seg_digit_monitor #(.STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b0), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  seg_digit_monitor #(.STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b1), .CNT_W(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model state: the current run of identical samples and the
  // acceptance history expressed directly in terms of digits.
  logic [6:0] m_cur, m_last;
  int         m_run;
  bit         m_done, m_have;
  int         m_prev;
  logic [7:0] m_cnt;
  bit         m_vld, m_err, m_ill;

  int n_vld, n_err, n_ill;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 10; i++)
      if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_cur = 7'h00; m_last = 7'h00; m_run = 0; m_done = 1'b1;
    m_have = 1'b0; m_prev = 0; m_cnt = 8'h00;
    m_vld = 1'b0; m_err = 1'b0; m_ill = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] p);
    int d;
    m_vld = 1'b0; m_err = 1'b0; m_ill = 1'b0;
    if (m_run >= STABLE && !m_done) begin
      m_done = 1'b1;
      if (m_cur != m_last) begin
        m_last = m_cur;
        d = lookup(m_cur);
        if (d >= 0) begin
          m_vld = 1'b1;
          m_err = m_have && (d != (m_prev + 1) % 10);
          m_prev = d;
          m_have = 1'b1;
          m_cnt++;
        end else begin
          m_ill  = (m_cur != 7'h00);
          m_have = 1'b0;
        end
      end
    end
    if (p[6:0] == m_cur) begin
      if (m_run < STABLE) m_run++;
    end else begin
      m_cur = p[6:0]; m_run = 1; m_done = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_pack();
    return {16'h0, 4'(m_prev), m_vld, m_err, m_ill, m_have, m_cnt};
  endfunction

  task automatic check_outputs();
    chk("a_out", {16'h0, bus_a.digit_out, bus_a.digit_vld, bus_a.step_err,
                  bus_a.seg_illegal, bus_a.locked, bus_a.chg_cnt}, exp_pack());
    chk("b_out", {16'h0, bus_b.digit_out, bus_b.digit_vld, bus_b.step_err,
                  bus_b.seg_illegal, bus_b.locked, bus_b.chg_cnt}, exp_pack());
  endtask

  // One clock: drive both buses (b sees the electrically inverted bus), step model, check.
  task automatic cycle(input logic [7:0] p);
    bus_a.seg_in = p;
    bus_b.seg_in = ~p;
    @(posedge clk);
    model_step(p);
    #1;
    check_outputs();
    n_vld += int'(bus_a.digit_vld);
    n_err += int'(bus_a.step_err);
    n_ill += int'(bus_a.seg_illegal);
  endtask

  task automatic hold(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) cycle(p);
  endtask

  // Asserted mid-cycle so the asynchronous clear is visible before any edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_outputs();
    end
    rst = 1'b0;
    n_vld = 0; n_err = 0; n_ill = 0;
  endtask

  initial begin
    logic [7:0] p, cnt_save;
    int kind, d;
    bus_a.seg_in = 8'h00;
    bus_b.seg_in = 8'hFF;
    model_reset();
    do_reset();

    // Single digit after reset
    hold(8'h3F, 6);
    chk("t1_vld", 32'(n_vld), 32'd1);
    chk("t1_err", 32'(n_err), 32'd0);
    chk("t1_dig", 32'(bus_a.digit_out), 32'd0);
    chk("t1_lock", 32'(bus_a.locked), 32'd1);
    chk("t1_cnt", 32'(bus_a.chg_cnt), 32'd1);

    // Full 0..9 then 0 sequence
    do_reset();
    for (int i = 0; i <= 10; i++) hold({1'b0, seg_tab[i % 10]}, 6);
    chk("t2_vld", 32'(n_vld), 32'd11);
    chk("t2_err", 32'(n_err), 32'd0);
    chk("t2_cnt", 32'(bus_a.chg_cnt), 32'd11);
    chk("t2_dig", 32'(bus_a.digit_out), 32'd0);

    // Skip 0 -> 2
    do_reset();
    hold(8'h3F, 6);
    hold(8'h5B, 6);
    chk("t3_err", 32'(n_err), 32'd1);
    chk("t3_dig", 32'(bus_a.digit_out), 32'd2);

    // Short glitch is filtered, re-accepting 1 is silent
    do_reset();
    hold(8'h06, 6);
    cnt_save = bus_a.chg_cnt;
    hold(8'h07, 2);
    hold(8'h06, 6);
    chk("t4_vld", 32'(n_vld), 32'd1);
    chk("t4_dig", 32'(bus_a.digit_out), 32'd1);
    chk("t4_cnt", 32'(bus_a.chg_cnt), 32'(cnt_save));

    // Illegal pattern drops lock; next digit is not step-checked
    hold(8'h49, 6);
    chk("t5_ill", 32'(n_ill), 32'd1);
    chk("t5_unlk", 32'(bus_a.locked), 32'd0);
    chk("t5_hold", 32'(bus_a.digit_out), 32'd1);
    hold(8'h5B, 6);
    chk("t5_err", 32'(n_err), 32'd0);
    chk("t5_lock", 32'(bus_a.locked), 32'd1);
    chk("t5_dig", 32'(bus_a.digit_out), 32'd2);

    // Reset into a run; active-low instance then sees C0 (= digit 0)
    do_reset();
    hold(8'h3F, 6);
    hold(8'h4F, 2);
    do_reset();
    chk("t6_clr", {16'h0, bus_a.digit_out, bus_a.digit_vld, bus_a.step_err,
                   bus_a.seg_illegal, bus_a.locked, bus_a.chg_cnt}, 32'd0);
    hold(8'h3F, 5);
    chk("t6_bvld", 32'(bus_b.digit_vld), 32'd1);
    chk("t6_bdig", 32'(bus_b.digit_out), 32'd0);

    // Randomized segments: mostly digits, some sequential, blanks, illegals, glitches
    for (int s = 0; s < 300; s++) begin
      kind = int'($urandom_range(0, 99));
      if (kind < 30) begin
        p = {1'b0, seg_tab[(m_prev + 1) % 10]};
      end else if (kind < 60) begin
        p = {1'b0, seg_tab[$urandom_range(0, 9)]};
      end else if (kind < 72) begin
        p = 8'h00;
      end else if (kind < 88) begin
        p = 8'($urandom_range(1, 127));
        for (int g = 0; g < 8 && lookup(p[6:0]) >= 0; g++) p = 8'($urandom_range(1, 127));
      end else begin
        p = 8'($urandom_range(0, 255));
      end
      p[7] = 1'($urandom_range(0, 1));
      d = int'($urandom_range(1, 7));
      hold(p, d);
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
